// File: rtl/geiger_pkg.sv
// -----------------------------------------------------------------------------
// geiger_pkg
// Shared definitions for the Geiger record packer. It defines the record field
// widths, the bit offsets of each field, the pulse-count ceiling, and the
// functions that pack and unpack a record.
//
// Record layout (REC_W = 48 bits):
//   GEIGER_PARITY_EN undefined : {TS[23:0], CNT_A[11:0], CNT_B[11:0]}
//   GEIGER_PARITY_EN defined   : {P, TS[22:0], CNT_A[11:0], CNT_B[11:0]}
//                                P makes bits [47:0] even parity.
// -----------------------------------------------------------------------------
package geiger_pkg;

    localparam int REC_W = 48;
    localparam int CNT_W = 12;
`ifdef GEIGER_PARITY_EN
    localparam int TS_W  = 23;
`else
    localparam int TS_W  = 24;
`endif

    localparam int CNT_B_LSB = 0;
    localparam int CNT_A_LSB = CNT_W;
    localparam int TS_LSB    = 2 * CNT_W;
    localparam int PAR_BIT   = REC_W - 1;

    localparam logic [CNT_W-1:0] CNT_MAX = 12'd4095;

    // The parity bit equals the XOR of the covered bits, so that the whole
    // record contains an even number of ones.
    function automatic logic even_parity(input logic [REC_W-2:0] bits);
        return ^bits;
    endfunction

    function automatic logic [REC_W-1:0] pack_record(
        input logic [TS_W-1:0]  ts,
        input logic [CNT_W-1:0] cnt_a,
        input logic [CNT_W-1:0] cnt_b
    );
        logic [REC_W-1:0] rec;
        rec = {REC_W{1'b0}};
        rec[TS_LSB +: TS_W]       = ts;
        rec[CNT_A_LSB +: CNT_W]   = cnt_a;
        rec[CNT_B_LSB +: CNT_W]   = cnt_b;
`ifdef GEIGER_PARITY_EN
        rec[PAR_BIT] = even_parity(rec[REC_W-2:0]);
`endif
        return rec;
    endfunction

    function automatic logic [TS_W-1:0] unpack_ts(input logic [REC_W-1:0] rec);
        return rec[TS_LSB +: TS_W];
    endfunction

    function automatic logic [CNT_W-1:0] unpack_cnt_a(input logic [REC_W-1:0] rec);
        return rec[CNT_A_LSB +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] unpack_cnt_b(input logic [REC_W-1:0] rec);
        return rec[CNT_B_LSB +: CNT_W];
    endfunction

endpackage

// File: rtl/geiger_pulse_sync.sv
// -----------------------------------------------------------------------------
// geiger_pulse_sync
// This block synchronizes an asynchronous tube pulse through two flip-flops.
// It then detects the rising edge of the synchronized level.
//
// Ports:
//   clk_i   in   system clock
//   rst_ni  in   synchronous active-low reset; clears every flop
//   pulse_i in   asynchronous tube pulse
//   rise_o  out  one-cycle strobe, high in the cycle after the second sync
//                stage sees the new level. A counter that registers this
//                strobe changes 3 edges after the input rises.
//
// This block has no configuration macro. The record format macro
// GEIGER_PARITY_EN does not affect it.
// -----------------------------------------------------------------------------
module geiger_pulse_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pulse_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two-stage synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pulse_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/geiger_record_packer.sv
// -----------------------------------------------------------------------------
// geiger_record_packer
// This block counts the pulses from two Geiger tubes over a fixed window of
// clock cycles. When each window closes, it packs a timestamped record. It
// stores the records in a small FIFO. It presents them on a registered output.
// Each presented record stays stable for at least MIN_HOLD cycles before the
// consumer can accept it.
//
// Ports:
//   CLK_1MHZ      in   system clock
//   RESET_N       in   synchronous active-low reset; clears all state
//   GEIG_PULSE_A  in   tube A pulse (async), one count per rising edge
//   GEIG_PULSE_B  in   tube B pulse (async), one count per rising edge
//   OUT_READY     in   consumer accepts the presented record
//   DATA_OUT      out  presented record (48 bits)
//   OUT_VALID     out  DATA_OUT holds a record that has not been accepted
//   OVERFLOW_CNT  out  number of records dropped on a full FIFO, saturating
//
// Configuration macro: GEIGER_PARITY_EN. When defined, it selects a 23-bit
// timestamp plus an even-parity bit in bit 47. The format is defined in
// geiger_pkg.
// -----------------------------------------------------------------------------
module geiger_record_packer
    import geiger_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1000000,
    parameter int FIFO_DEPTH    = 4,
    parameter int MIN_HOLD      = 8
) (
    input  logic             CLK_1MHZ,
    input  logic             RESET_N,
    input  logic             GEIG_PULSE_A,
    input  logic             GEIG_PULSE_B,
    input  logic             OUT_READY,
    output logic [REC_W-1:0] DATA_OUT,
    output logic             OUT_VALID,
    output logic [7:0]       OVERFLOW_CNT
);

    localparam int WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int HOLD_W = $clog2(MIN_HOLD);

    localparam logic [WIN_W-1:0]  WIN_LAST      = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT     = HOLD_W'(MIN_HOLD - 1);
    localparam logic [PTR_W:0]    FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    // Pulse front end
    logic rise_a_s;
    logic rise_b_s;

    geiger_pulse_sync u_sync_a (
        .clk_i   (CLK_1MHZ),
        .rst_ni  (RESET_N),
        .pulse_i (GEIG_PULSE_A),
        .rise_o  (rise_a_s)
    );

    geiger_pulse_sync u_sync_b (
        .clk_i   (CLK_1MHZ),
        .rst_ni  (RESET_N),
        .pulse_i (GEIG_PULSE_B),
        .rise_o  (rise_b_s)
    );

    // Window / counters / timestamp
    logic [WIN_W-1:0] win_q,   win_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic [TS_W-1:0]  ts_q,    ts_d;

    logic             wc_s;
    logic [CNT_W-1:0] cnt_a_inc_s;
    logic [CNT_W-1:0] cnt_b_inc_s;
    logic [REC_W-1:0] record_s;

    assign wc_s = (win_q == WIN_LAST);

    // The record captures the counts including an edge detected in the
    // window-close cycle itself, so the saturating increment is formed here.
    assign cnt_a_inc_s = (rise_a_s && (cnt_a_q != CNT_MAX)) ? cnt_a_q + 12'd1 : cnt_a_q;
    assign cnt_b_inc_s = (rise_b_s && (cnt_b_q != CNT_MAX)) ? cnt_b_q + 12'd1 : cnt_b_q;
    assign record_s    = pack_record(ts_q, cnt_a_inc_s, cnt_b_inc_s);

    // Next state of the window counter, the pulse counters and the timestamp.
    always_comb begin
        win_d   = wc_s ? {WIN_W{1'b0}} : win_q + WIN_W'(1);
        cnt_a_d = wc_s ? {CNT_W{1'b0}} : cnt_a_inc_s;
        cnt_b_d = wc_s ? {CNT_W{1'b0}} : cnt_b_inc_s;
        ts_d    = wc_s ? ts_q + TS_W'(1) : ts_q;
    end

    // FIFO and output stage
    logic [REC_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   fifo_cnt_q, fifo_cnt_d;

    logic [REC_W-1:0]  data_q,  data_d;
    logic              valid_q, valid_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [7:0]        ovf_q,   ovf_d;

    logic fifo_empty_s;
    logic fifo_full_s;
    logic accept_s;
    logic load_s;
    logic push_s;
    logic drop_s;

    assign fifo_empty_s = (fifo_cnt_q == {(PTR_W + 1){1'b0}});
    assign fifo_full_s  = (fifo_cnt_q == FIFO_FULL_CNT);
    assign accept_s     = valid_q & OUT_READY & (hold_q == {HOLD_W{1'b0}});
    assign load_s       = ~fifo_empty_s & (~valid_q | accept_s);
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign push_s       = wc_s & (~fifo_full_s | load_s);
    assign drop_s       = wc_s & fifo_full_s & ~load_s;

    // Next state of the FIFO pointers, the occupancy and the overflow count.
    always_comb begin
        wr_ptr_d   = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = load_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + (PTR_W + 1)'(push_s) - (PTR_W + 1)'(load_s);
        ovf_d      = (drop_s && (ovf_q != 8'hFF)) ? ovf_q + 8'd1 : ovf_q;
    end

    // Next state of the output register. After the last accept, DATA_OUT
    // keeps the old value so that the serializer sees no change.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        if (load_s) begin
            data_d  = fifo_mem_q[rd_ptr_q];
            valid_d = 1'b1;
            hold_d  = HOLD_INIT;
        end else begin
            if (accept_s) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
            if (hold_q != {HOLD_W{1'b0}}) begin
                hold_d = hold_q - HOLD_W'(1);
            end else begin
                hold_d = hold_q;
            end
        end
    end

    // State registers, including the FIFO storage.
    always_ff @(posedge CLK_1MHZ) begin
        if (!RESET_N) begin
            win_q      <= {WIN_W{1'b0}};
            cnt_a_q    <= {CNT_W{1'b0}};
            cnt_b_q    <= {CNT_W{1'b0}};
            ts_q       <= {TS_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            fifo_cnt_q <= {(PTR_W + 1){1'b0}};
            data_q     <= {REC_W{1'b0}};
            valid_q    <= 1'b0;
            hold_q     <= {HOLD_W{1'b0}};
            ovf_q      <= 8'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= {REC_W{1'b0}};
            end
        end else begin
            win_q      <= win_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            hold_q     <= hold_d;
            ovf_q      <= ovf_d;
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= record_s;
            end
        end
    end

    assign DATA_OUT     = data_q;
    assign OUT_VALID    = valid_q;
    assign OVERFLOW_CNT = ovf_q;

endmodule

// File: tb/tb_geiger_record_packer.sv
// -----------------------------------------------------------------------------
// tb_geiger_record_packer
// Instance u_dut_a (window of 100 cycles) runs against a reference model.
// The model tracks the record values and the presentation timing from the
// record rules:
//   - An input edge applied after edge e0 is counted in the window
//     floor((e0 + 2) / W).
//   - A record appears when its window closes.
//   - The capacity is the FIFO depth plus the output slot.
//   - A record is held for 8 cycles before it can be accepted.
// Instance u_dut_b (window of 20000 cycles) covers counter saturation.
// The bench follows the record format selected by GEIGER_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_geiger_record_packer;

    localparam int W     = 100;
    localparam int WB    = 20000;
    localparam int DEPTH = 4;
    localparam int HOLD  = 8;

    logic        clk;
    logic        rst_n_a, pa, pb, ready_a;
    logic [47:0] data_a;
    logic        valid_a;
    logic [7:0]  ovf_a;
    logic        rst_n_b, b_pa, b_pb, ready_b;
    logic [47:0] data_b;
    logic        valid_b;
    logic [7:0]  ovf_b;

    int n_vec;
    int n_err;
    int k;
    int kb;

    // Reference model state
    int          cnt_a [256];
    int          cnt_b [256];
    logic [47:0] mq [$];
    bit          m_valid;
    logic [47:0] m_data;
    int          m_load;
    int          m_ovf;

    geiger_record_packer #(.WINDOW_CYCLES(W), .FIFO_DEPTH(DEPTH), .MIN_HOLD(HOLD)) u_dut_a (
        .CLK_1MHZ     (clk),
        .RESET_N      (rst_n_a),
        .GEIG_PULSE_A (pa),
        .GEIG_PULSE_B (pb),
        .OUT_READY    (ready_a),
        .DATA_OUT     (data_a),
        .OUT_VALID    (valid_a),
        .OVERFLOW_CNT (ovf_a)
    );

    geiger_record_packer #(.WINDOW_CYCLES(WB), .FIFO_DEPTH(DEPTH), .MIN_HOLD(HOLD)) u_dut_b (
        .CLK_1MHZ     (clk),
        .RESET_N      (rst_n_b),
        .GEIG_PULSE_A (b_pa),
        .GEIG_PULSE_B (b_pb),
        .OUT_READY    (ready_b),
        .DATA_OUT     (data_b),
        .OUT_VALID    (valid_b),
        .OVERFLOW_CNT (ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int sat(input int x);
        return (x > 4095) ? 4095 : x;
    endfunction

    function automatic logic [47:0] exp_rec(input int ts, input int a, input int b);
        logic [47:0] r;
`ifdef GEIGER_PARITY_EN
        r = {1'b0, 23'(ts), 12'(a), 12'(b)};
        r[47] = ^r[46:0];
`else
        r = {24'(ts), 12'(a), 12'(b)};
`endif
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d kb=%0d: got %h, expected %h", tag, k, kb, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        foreach (cnt_a[i]) begin
            cnt_a[i] = 0;
            cnt_b[i] = 0;
        end
        mq.delete();
        m_valid = 1'b0;
        m_data  = 48'h0;
        m_load  = 0;
        m_ovf   = 0;
    endtask

    // One clock edge of the model. k has already been advanced to this edge.
    task automatic model_edge(input bit rdy);
        bit acc, ld, psh;
        int w;
        logic [47:0] rec;
        acc = m_valid && rdy && ((k - m_load) >= HOLD);
        ld  = (mq.size() > 0) && (!m_valid || acc);
        psh = 1'b0;
        rec = 48'h0;
        if (k % W == 0) begin
            w   = k / W - 1;
            rec = exp_rec(w, sat(cnt_a[w % 256]), sat(cnt_b[w % 256]));
            cnt_a[w % 256] = 0;
            cnt_b[w % 256] = 0;
            if ((mq.size() < DEPTH) || ld) psh = 1'b1;
            else if (m_ovf < 255) m_ovf++;
        end
        if (ld) begin
            m_data  = mq.pop_front();
            m_valid = 1'b1;
            m_load  = k;
        end else if (acc) begin
            m_valid = 1'b0;
        end
        if (psh) mq.push_back(rec);
    endtask

    task automatic note_a();
        cnt_a[((k + 2) / W) % 256]++;
    endtask

    task automatic note_b();
        cnt_b[((k + 2) / W) % 256]++;
    endtask

    // Random one-cycle pulses that are always separated by a low cycle.
    task automatic drive_random(input int pct_a, input int pct_b);
        if (pa) pa = 1'b0;
        else if (int'($urandom_range(99)) < pct_a) begin
            pa = 1'b1;
            note_a();
        end
        if (pb) pb = 1'b0;
        else if (int'($urandom_range(99)) < pct_b) begin
            pb = 1'b1;
            note_b();
        end
    endtask

    // Apply the current inputs at the next edge, advance the model, and
    // compare instance A against the model.
    task automatic tick();
        bit rdy, rst;
        rdy = ready_a;
        rst = rst_n_a;
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else begin
            k++;
            model_edge(rdy);
        end
        check_eq("out_valid", 48'(valid_a), 48'(m_valid));
        check_eq("overflow_cnt", 48'(ovf_a), 48'(m_ovf));
        check_eq("data_out", data_a, m_data);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        k = 0;
        kb = 0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        pa = 1'b0;
        pb = 1'b0;
        b_pa = 1'b0;
        b_pb = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        model_reset();
        tick();
        tick();
        check_eq("reset_data", data_a, 48'h0);
        check_eq("reset_valid", 48'(valid_a), 48'h0);
        check_eq("reset_ovf", 48'(ovf_a), 48'h0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Directed window 0 (5 A, 3 B). Also an edge on the close cycle versus
        // an edge on the cycle after it.
        while (k < 420) begin
            pa = (k == 10 || k == 12 || k == 14 || k == 16 || k == 18 || k == 297);
            pb = (k == 10 || k == 14 || k == 18 || k == 298);
            if (pa) note_a();
            if (pb) note_b();
            tick();
            case (k)
                100: check_eq("first_latency_valid", 48'(valid_a), 48'h0);
                101: begin
                    check_eq("first_record", data_a, 48'h000000005003);
                    check_eq("first_valid", 48'(valid_a), 48'h1);
                end
                108: check_eq("hold_valid", 48'(valid_a), 48'h1);
                109: begin
                    check_eq("accept_valid", 48'(valid_a), 48'h0);
                    check_eq("accept_data_kept", data_a, 48'h000000005003);
                end
                201: check_eq("second_record_ts1", data_a, exp_rec(1, 0, 0));
                301: check_eq("edge_on_wc", data_a, exp_rec(2, 1, 0));
                401: check_eq("edge_after_wc", data_a, exp_rec(3, 0, 1));
                default: ;
            endcase
        end

        // Backpressure over 6 windows: the FIFO and output fill, then one drop.
        ready_a = 1'b0;
        while (k < 1010) begin
            drive_random(30, 30);
            tick();
            if (k == 999)  check_eq("ovf_before_drop", 48'(ovf_a), 48'h0);
            if (k == 1000) check_eq("ovf_after_drop", 48'(ovf_a), 48'h1);
        end
        ready_a = 1'b1;
        while (k < 1100) begin
            drive_random(20, 20);
            tick();
            if (k == 1060) begin
                check_eq("drained_valid", 48'(valid_a), 48'h0);
                check_eq("drained_ovf", 48'(ovf_a), 48'h1);
            end
        end

        // READY is asserted only while the hold time is still running.
        while (k < 1400) begin
            drive_random(20, 20);
            ready_a = m_valid && ((k + 1 - m_load) < HOLD);
            tick();
        end
        check_eq("hold_ready_ignored_valid", 48'(valid_a), 48'h1);
        check_eq("hold_ready_ignored_ts", 48'(data_a[46:24]), 48'd10);

        // Random traffic
        while (k < 2400) begin
            drive_random(40, 40);
            ready_a = ($urandom_range(1) == 1);
            tick();
        end

        // Queue records, then reset mid-window.
        ready_a = 1'b0;
        while (k < 2650) begin
            drive_random(30, 30);
            tick();
        end
        rst_n_a = 1'b0;
        pa = 1'b0;
        pb = 1'b0;
        tick();
        check_eq("midreset_data", data_a, 48'h0);
        check_eq("midreset_valid", 48'(valid_a), 48'h0);
        check_eq("midreset_ovf", 48'(ovf_a), 48'h0);
        rst_n_a = 1'b1;
        ready_a = 1'b1;
        while (k < 250) begin
            drive_random(30, 30);
            tick();
            if (k == 101) begin
                check_eq("post_reset_valid", 48'(valid_a), 48'h1);
                check_eq("post_reset_ts0", 48'(data_a[46:24]), 48'h0);
            end
        end

        // Saturation on instance B: 5000 A pulses in one window.
        pa = 1'b0;
        pb = 1'b0;
        rst_n_b = 1'b0;
        tick();
        rst_n_b = 1'b1;
        kb = 0;
        check_eq("b_reset_data", data_b, 48'h0);
        check_eq("b_reset_valid", 48'(valid_b), 48'h0);
        for (int i = 0; i < 40005; i++) begin
            b_pa = ((kb < 10000) && (kb % 2 == 0)) || (kb == 20100) || (kb == 20102) || (kb == 20104);
            tick();
            kb++;
            case (kb)
                20000: check_eq("b_before_close_valid", 48'(valid_b), 48'h0);
                20001: begin
                    check_eq("b_saturated_record", data_b, exp_rec(0, 4095, 0));
                    check_eq("b_saturated_valid", 48'(valid_b), 48'h1);
                end
                40001: begin
                    check_eq("b_restart_record", data_b, exp_rec(1, 3, 0));
                    check_eq("b_restart_valid", 48'(valid_b), 48'h1);
                end
                default: ;
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
